fc_act_loader: RTL

//  Upstream stage of a combinational fully-connected neuron layer. Deserialises a stream of

---
 rtl/fc_act_loader.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fc_act_loader.sv
// Deserialises a valid/ready activation stream into the x[] array of a combinational FC layer,
// waits SETTLE cycles after the final beat, then holds x with x_valid until the consumer takes it.
module fc_act_loader #(
  parameter int WIDTH  = 8,
  parameter int IN     = 400,
  parameter int SETTLE = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     s_first,
  input  logic                     s_last,
  output logic [WIDTH-1:0]         x [0:IN-1],
  output logic                     x_valid,
  input  logic                     x_ready,
  output logic [$clog2(IN+1)-1:0]  count,
  output logic                     frame_err,
  input  logic                     err_clr
);

  localparam int CW = $clog2(IN + 1);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_INIT = (SETTLE > 0) ? SW'(SETTLE - 1) : '0;
  localparam logic [CW-1:0] LAST_IDX    = CW'(IN - 1);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SETTLE,
    ST_HOLD
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [SW-1:0]   settle_reg, settle_next;
  logic            frame_err_reg, frame_err_next;
  logic            err_set;
  logic            load_beat;
  logic [CW-1:0]   wr_idx;
  logic [WIDTH-1:0] x_reg [0:IN-1];

  // A beat flagged s_first always restarts the frame at entry 0, dropping any partial frame.
  assign load_beat = s_valid && (state_reg == ST_LOAD);
  assign wr_idx    = s_first ? '0 : count_reg;

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    settle_next = settle_reg;
    err_set     = 1'b0;
    s_ready     = 1'b0;
    x_valid     = 1'b0;
    case (state_reg)
      ST_LOAD: begin
        s_ready = 1'b1;
        if (load_beat) begin
          if (s_first && (count_reg != '0)) err_set = 1'b1;
          if (wr_idx == LAST_IDX) begin
            if (!s_last) err_set = 1'b1;
            count_next = '0;
            if (SETTLE == 0) begin
              state_next = ST_HOLD;
            end else begin
              state_next  = ST_SETTLE;
              settle_next = SETTLE_INIT;
            end
          end else if (s_last) begin
            err_set    = 1'b1;
            count_next = '0;
          end else begin
            count_next = wr_idx + 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        if (settle_reg == '0) state_next = ST_HOLD;
        else settle_next = settle_reg - 1'b1;
      end
      ST_HOLD: begin
        x_valid = 1'b1;
        if (x_ready) state_next = ST_LOAD;
      end
      default: state_next = ST_LOAD;
    endcase
  end

  // An error raised in the same cycle as err_clr must survive the clear.
  assign frame_err_next = err_set ? 1'b1 : (err_clr ? 1'b0 : frame_err_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_LOAD;
      count_reg     <= '0;
      settle_reg    <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      settle_reg    <= settle_next;
      frame_err_reg <= frame_err_next;
    end
  end

  generate
    for (genvar gi = 0; gi < IN; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          x_reg[gi] <= '0;
        end else if (load_beat && (wr_idx == CW'(gi))) begin
          x_reg[gi] <= s_data;
        end
      end
      assign x[gi] = x_reg[gi];
    end
  endgenerate

  assign count     = count_reg;
  assign frame_err = frame_err_reg;

endmodule
